// File: rtl/slink_apb_app_completer.sv
// APB completer with a small CSR file, programmable wait states and a level interrupt.
// Optional feature: define SLINK_APB_COMPLETER_PSLVERR_EN to flag address misses with pslverr.
module slink_apb_app_completer #(
    parameter int unsigned APB_ADDR_WIDTH    = 32,
    parameter logic [31:0] ID_VALUE          = 32'h534C_0001,
    parameter int unsigned DEFAULT_WAIT      = 0,
    // Reset value of ACCESS_COUNT; nonzero only to reach the wrap point quickly
    parameter logic [15:0] ACCESS_COUNT_INIT = 16'h0000
) (
    input  logic                      apb_clk,
    input  logic                      apb_reset,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr,
    input  logic                      apb_pwrite,
    input  logic                      apb_psel,
    input  logic                      apb_penable,
    input  logic [31:0]               apb_pwdata,
    output logic [31:0]               apb_prdata,
    output logic                      apb_pready,
    output logic                      apb_pslverr,
    input  logic [3:0]                irq_event,
    output logic                      interrupt
);

    typedef enum logic {StIdle, StAccess} state_e;

    localparam logic [3:0] DefWait = 4'(DEFAULT_WAIT);

    state_e      state_q;
    logic [3:0]  wait_cnt_q;
    logic [31:0] scratch_q;
    logic [3:0]  wait_cfg_q;
    logic [3:0]  int_status_q, int_status_d;
    logic [3:0]  int_en_q;
    logic [15:0] access_count_q;
    logic        interrupt_q;

    logic [4:0] addr_lo;
    logic [2:0] reg_idx;
    logic       upper_zero;
    logic       hit;
    logic       xfer_done;
    logic       wr_hit;
    logic       rd_hit;

    assign addr_lo    = apb_paddr[4:0];
    assign reg_idx    = addr_lo[4:2];
    assign upper_zero = ((apb_paddr >> 5) == '0);
    assign hit        = upper_zero && (addr_lo[1:0] == 2'b00) && (addr_lo <= 5'h18);

    // The completing cycle is the only cycle with any register side effect
    assign xfer_done = (state_q == StAccess) && apb_psel && apb_penable && (wait_cnt_q == 4'd0);
    assign wr_hit    = xfer_done && apb_pwrite && hit;
    assign rd_hit    = xfer_done && !apb_pwrite && hit;

    assign apb_pready = xfer_done;
    assign interrupt  = interrupt_q;

`ifdef SLINK_APB_COMPLETER_PSLVERR_EN
    assign apb_pslverr = xfer_done && !hit;
`else
    assign apb_pslverr = 1'b0;
`endif

    always_comb begin
        apb_prdata = 32'h0;
        if (rd_hit) begin
            case (reg_idx)
                3'd0:    apb_prdata = ID_VALUE;
                3'd1:    apb_prdata = scratch_q;
                3'd2:    apb_prdata = {28'h0, wait_cfg_q};
                3'd3:    apb_prdata = {28'h0, int_status_q};
                3'd4:    apb_prdata = {28'h0, int_en_q};
                3'd6:    apb_prdata = {16'h0, access_count_q};
                default: apb_prdata = 32'h0;
            endcase
        end
    end

    // Set (event or INT_SET) takes priority over a W1C clear in the same cycle
    always_comb begin
        logic [3:0] set_v;
        logic [3:0] clr_v;
        set_v = irq_event;
        clr_v = 4'h0;
        if (wr_hit && (reg_idx == 3'd5)) set_v = set_v | apb_pwdata[3:0];
        if (wr_hit && (reg_idx == 3'd3)) clr_v = apb_pwdata[3:0];
        int_status_d = set_v | (int_status_q & ~clr_v);
    end

    always_ff @(posedge apb_clk or negedge apb_reset) begin
        if (!apb_reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (apb_psel && !apb_penable) begin
                        state_q    <= StAccess;
                        wait_cnt_q <= wait_cfg_q;
                    end
                end
                StAccess: begin
                    if (!apb_psel) begin
                        state_q    <= StIdle;
                        wait_cnt_q <= 4'd0;
                    end else if (apb_penable) begin
                        if (wait_cnt_q == 4'd0) begin
                            state_q <= StIdle;
                        end else begin
                            wait_cnt_q <= wait_cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    wait_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge apb_clk or negedge apb_reset) begin
        if (!apb_reset) begin
            scratch_q      <= 32'h0;
            wait_cfg_q     <= DefWait;
            int_status_q   <= 4'h0;
            int_en_q       <= 4'h0;
            access_count_q <= ACCESS_COUNT_INIT;
            interrupt_q    <= 1'b0;
        end else begin
            if (wr_hit) begin
                case (reg_idx)
                    3'd1:    scratch_q  <= apb_pwdata;
                    3'd2:    wait_cfg_q <= apb_pwdata[3:0];
                    3'd4:    int_en_q   <= apb_pwdata[3:0];
                    default: ;
                endcase
            end
            if (xfer_done) access_count_q <= access_count_q + 16'd1;
            int_status_q <= int_status_d;
            interrupt_q  <= |(int_status_q & int_en_q);
        end
    end

endmodule

// File: tb/tb_slink_apb_app_completer.sv
// Directed bench for slink_apb_app_completer with a read-data scoreboard queue.
module tb_slink_apb_app_completer;

    logic        apb_clk;
    logic        apb_reset;
    logic [31:0] apb_paddr;
    logic        apb_pwrite;
    logic        apb_psel;
    logic        apb_penable;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic        apb_pslverr;
    logic [3:0]  irq_event;
    logic        interrupt;

    localparam logic [15:0] CntInit = 16'hFFF0;
    localparam logic [31:0] IdVal   = 32'h534C_0001;

`ifdef SLINK_APB_COMPLETER_PSLVERR_EN
    localparam logic MissErr = 1'b1;
`else
    localparam logic MissErr = 1'b0;
`endif

    slink_apb_app_completer #(
        .APB_ADDR_WIDTH   (32),
        .ID_VALUE         (IdVal),
        .DEFAULT_WAIT     (0),
        .ACCESS_COUNT_INIT(CntInit)
    ) dut (
        .apb_clk    (apb_clk),
        .apb_reset  (apb_reset),
        .apb_paddr  (apb_paddr),
        .apb_pwrite (apb_pwrite),
        .apb_psel   (apb_psel),
        .apb_penable(apb_penable),
        .apb_pwdata (apb_pwdata),
        .apb_prdata (apb_prdata),
        .apb_pready (apb_pready),
        .apb_pslverr(apb_pslverr),
        .irq_event  (irq_event),
        .interrupt  (interrupt)
    );

    initial apb_clk = 1'b0;
    always #5 apb_clk = ~apb_clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] model_cnt;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One APB transfer; irq_acc is driven during the first access cycle.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input int exp_cyc, input logic exp_err, input logic [3:0] irq_acc);
        int          cyc;
        logic        done;
        logic [31:0] rd;
        logic        err;
        logic [31:0] exp_v;
        @(posedge apb_clk); #1;
        apb_psel = 1'b1; apb_penable = 1'b0;
        apb_paddr = addr; apb_pwrite = wr; apb_pwdata = wdata;
        if (!wr) exp_q.push_back(exp_rd);
        @(posedge apb_clk); #1;
        apb_penable = 1'b1;
        irq_event   = irq_acc;
        cyc = 0; done = 1'b0; rd = 32'h0; err = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge apb_clk);
            cyc++;
            if (apb_pready) begin
                done = 1'b1;
                rd   = apb_prdata;
                err  = apb_pslverr;
            end
        end
        if (!done) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            if (!wr) void'(exp_q.pop_front());
        end else begin
            model_cnt = model_cnt + 16'd1;
            chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
            chk({tag, "_pslverr"}, {31'h0, err}, {31'h0, exp_err});
            if (!wr) begin
                exp_v = exp_q.pop_front();
                chk({tag, "_rdata"}, rd, exp_v);
            end
        end
        @(posedge apb_clk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0; irq_event = 4'h0;
    endtask

    initial begin
        apb_reset = 1'b0; apb_paddr = '0; apb_pwrite = 1'b0; apb_psel = 1'b0;
        apb_penable = 1'b0; apb_pwdata = '0; irq_event = 4'h0;
        model_cnt = CntInit;
        #12;
        chk("rst_pready", {31'h0, apb_pready}, 32'h0);
        chk("rst_pslverr", {31'h0, apb_pslverr}, 32'h0);
        chk("rst_prdata", apb_prdata, 32'h0);
        chk("rst_irq", {31'h0, interrupt}, 32'h0);
        @(negedge apb_clk); apb_reset = 1'b1;

        xfer("id", 32'h00, 1'b0, 0, IdVal, 1, 1'b0, 4'h0);
        xfer("wcfg", 32'h08, 1'b1, 3, 0, 1, 1'b0, 4'h0);
        xfer("scr_wr", 32'h04, 1'b1, 32'hDEADBEEF, 0, 4, 1'b0, 4'h0);
        xfer("scr_rd", 32'h04, 1'b0, 0, 32'hDEADBEEF, 4, 1'b0, 4'h0);
        xfer("wcfg_rd", 32'h08, 1'b0, 0, 32'h3, 4, 1'b0, 4'h0);
        xfer("wcfg0", 32'h08, 1'b1, 0, 0, 4, 1'b0, 4'h0);

        xfer("inten", 32'h10, 1'b1, 32'h5, 0, 1, 1'b0, 4'h0);
        @(posedge apb_clk); #1 irq_event = 4'h1;
        @(posedge apb_clk); #1 irq_event = 4'h0;
        chk("irq_lag", {31'h0, interrupt}, 32'h0);
        @(posedge apb_clk); #1;
        chk("irq_set", {31'h0, interrupt}, 32'h1);
        xfer("sts1", 32'h0C, 1'b0, 0, 32'h1, 1, 1'b0, 4'h0);
        xfer("w1c_race", 32'h0C, 1'b1, 32'h1, 0, 1, 1'b0, 4'h1);
        xfer("sts_race", 32'h0C, 1'b0, 0, 32'h1, 1, 1'b0, 4'h0);
        xfer("w1c", 32'h0C, 1'b1, 32'h1, 0, 1, 1'b0, 4'h0);
        chk("irq_clr_lag", {31'h0, interrupt}, 32'h1);
        @(posedge apb_clk); #1;
        chk("irq_clr", {31'h0, interrupt}, 32'h0);
        xfer("sts0", 32'h0C, 1'b0, 0, 32'h0, 1, 1'b0, 4'h0);
        xfer("intset", 32'h14, 1'b1, 32'h2, 0, 1, 1'b0, 4'h0);
        xfer("sts2", 32'h0C, 1'b0, 0, 32'h2, 1, 1'b0, 4'h0);
        xfer("intset_rd", 32'h14, 1'b0, 0, 32'h0, 1, 1'b0, 4'h0);
        xfer("w1c2", 32'h0C, 1'b1, 32'h2, 0, 1, 1'b0, 4'h0);
        @(posedge apb_clk); #1;
        chk("irq_masked", {31'h0, interrupt}, 32'h0);
        xfer("cnt", 32'h18, 1'b0, 0, {16'h0, model_cnt}, 1, 1'b0, 4'h0);

        xfer("miss_rd", 32'h1C, 1'b0, 0, 32'h0, 1, MissErr, 4'h0);
        xfer("miss_wr", 32'h06, 1'b1, 32'h12345678, 0, 1, MissErr, 4'h0);
        xfer("miss_hi", 32'h1000_0004, 1'b0, 0, 32'h0, 1, MissErr, 4'h0);
        xfer("scr_keep", 32'h04, 1'b0, 0, 32'hDEADBEEF, 1, 1'b0, 4'h0);

        // Reset asserted in a wait state of a SCRATCH write
        xfer("wcfg3", 32'h08, 1'b1, 3, 0, 1, 1'b0, 4'h0);
        @(posedge apb_clk); #1;
        apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = 32'h04;
        apb_pwrite = 1'b1; apb_pwdata = 32'hCAFEF00D;
        @(posedge apb_clk); #1 apb_penable = 1'b1;
        @(negedge apb_clk);
        chk("rw_wait1", {31'h0, apb_pready}, 32'h0);
        @(negedge apb_clk);
        chk("rw_wait2", {31'h0, apb_pready}, 32'h0);
        #2 apb_reset = 1'b0;
        #1;
        chk("rw_pready", {31'h0, apb_pready}, 32'h0);
        chk("rw_prdata", apb_prdata, 32'h0);
        @(posedge apb_clk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0;
        @(negedge apb_clk); apb_reset = 1'b1;
        model_cnt = CntInit;
        xfer("rw_scr", 32'h04, 1'b0, 0, 32'h0, 1, 1'b0, 4'h0);
        xfer("rw_wcfg", 32'h08, 1'b0, 0, 32'h0, 1, 1'b0, 4'h0);

        for (int i = 0; i < 20 && model_cnt != 16'hFFFF; i++) begin
            xfer("pre", 32'h00, 1'b0, 0, IdVal, 1, 1'b0, 4'h0);
        end
        xfer("cnt_ffff", 32'h18, 1'b0, 0, 32'h0000_FFFF, 1, 1'b0, 4'h0);
        xfer("cnt_wrap", 32'h18, 1'b0, 0, 32'h0000_0000, 1, 1'b0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
